// File: rtl/lookup_pkg.sv
// Shared definitions for the TIE lookup-RAM interface, used by both the
// initiator and responder sides.
package lookup_pkg;

    localparam int LOOKUP_ADDR_W = 8;
    localparam int LOOKUP_DATA_W = 32;
    localparam int LOOKUP_OUT_W  = 1 + LOOKUP_ADDR_W + LOOKUP_DATA_W;
    localparam int WR_BIT        = 40;
    localparam int ADDR_LSB      = 32;

    typedef logic [LOOKUP_OUT_W-1:0] lookup_out_t;

    // Read requests always carry a zero data field.
    function automatic lookup_out_t lookup_pack(input logic                     write,
                                                input logic [LOOKUP_ADDR_W-1:0] addr,
                                                input logic [LOOKUP_DATA_W-1:0] wdata);
        return {write, addr, (write ? wdata : {LOOKUP_DATA_W{1'b0}})};
    endfunction

    function automatic logic lookup_is_write(input lookup_out_t out);
        return out[WR_BIT];
    endfunction

    function automatic logic [LOOKUP_ADDR_W-1:0] lookup_addr(input lookup_out_t out);
        return out[WR_BIT-1:ADDR_LSB];
    endfunction

    function automatic logic [LOOKUP_DATA_W-1:0] lookup_wdata(input lookup_out_t out);
        return out[ADDR_LSB-1:0];
    endfunction

endpackage

// File: rtl/lookup_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; data output reads as zero
// while empty so the consumer never sees stale entries.
module lookup_rsp_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [DATA_W-1:0]      push_data_i,
    input  logic                   pop_i,
    output logic [DATA_W-1:0]      pop_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_i && !pop_i)      count_d = count_q + (PTR_W+1)'(1);
        else if (!push_i && pop_i) count_d = count_q - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/lookup_initiator.sv
// Initiator end of the TIE lookup-RAM interface: valid/ready command port in,
// fixed-latency request/capture toward the responder, buffered read responses out.
module lookup_initiator
    import lookup_pkg::*;
#(
    parameter int ADDR_W    = LOOKUP_ADDR_W,
    parameter int DATA_W    = LOOKUP_DATA_W,
    parameter int LATENCY   = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     Reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    output logic                     TIE_lookup_ram_Out_Req,
    output logic [ADDR_W+DATA_W:0]   TIE_lookup_ram_Out,
    input  logic [DATA_W-1:0]        TIE_lookup_ram_In,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy
);

    localparam int OUT_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    logic               out_req_q, out_req_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [LATENCY-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [SUM_W-1:0]   rd_cnt, outstanding;
    logic               issue_rd, credit_ok, accept, pop;

    // A read currently on the bus has not yet entered the in-flight pipe.
    assign issue_rd = out_req_q & ~out_q[OUT_W-1];

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < LATENCY; i++) rd_cnt = rd_cnt + SUM_W'(inflight_q[i]);
    end

    assign outstanding = rd_cnt + SUM_W'(fifo_cnt) + SUM_W'(issue_rd);
    assign credit_ok   = outstanding < SUM_W'(RSP_DEPTH);
    assign cmd_ready   = Reset_n & (cmd_write | credit_ok);
    assign accept      = cmd_valid & cmd_ready;

    always_comb begin
        out_req_d  = accept;
        out_d      = out_q;
        inflight_d = inflight_q;
        if (accept) out_d = {cmd_write, cmd_addr, (cmd_write ? cmd_wdata : {DATA_W{1'b0}})};
        inflight_d[0] = issue_rd;
        for (int i = 1; i < LATENCY; i++) inflight_d[i] = inflight_q[i-1];
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            out_req_q  <= 1'b0;
            out_q      <= '0;
            inflight_q <= '0;
        end else begin
            out_req_q  <= out_req_d;
            out_q      <= out_d;
            inflight_q <= inflight_d;
        end
    end

    // The last pipe stage marks the cycle the responder's data is valid.
    assign pop = rsp_valid & rsp_ready;

    lookup_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (CLK),
        .rst_ni      (Reset_n),
        .push_i      (inflight_q[LATENCY-1]),
        .push_data_i (TIE_lookup_ram_In),
        .pop_i       (pop),
        .pop_data_o  (rsp_data),
        .count_o     (fifo_cnt)
    );

    assign rsp_valid              = fifo_cnt != '0;
    assign busy                   = (|inflight_q) | (fifo_cnt != '0) | out_req_q;
    assign TIE_lookup_ram_Out_Req = out_req_q;
    assign TIE_lookup_ram_Out     = out_q;

endmodule

// File: tb/tb_lookup_initiator.sv
// Bench for lookup_initiator: a LATENCY=1 and a LATENCY=3 instance, a
// fixed-latency responder, a queue-based reference model and directed tests.
module tb_lookup_initiator;
    import lookup_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n, cmd_valid, cmd_ready, cmd_write, out_req, rsp_valid, rsp_ready, busy;
    logic [1:0][7:0]  cmd_addr;
    logic [1:0][31:0] cmd_wdata, ram_in, rsp_data;
    logic [1:0][40:0] ram_out;

    lookup_initiator #(.LATENCY(1), .RSP_DEPTH(DEPTH)) u_lat1 (
        .CLK(clk), .Reset_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .TIE_lookup_ram_Out_Req(out_req[0]), .TIE_lookup_ram_Out(ram_out[0]),
        .TIE_lookup_ram_In(ram_in[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .busy(busy[0]));

    lookup_initiator #(.LATENCY(3), .RSP_DEPTH(DEPTH)) u_lat3 (
        .CLK(clk), .Reset_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .TIE_lookup_ram_Out_Req(out_req[1]), .TIE_lookup_ram_Out(ram_out[1]),
        .TIE_lookup_ram_In(ram_in[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .busy(busy[1]));

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] resp_fn(input logic [7:0] a);
        return (a == 8'h12) ? 32'hDEADBEEF : (32'h100 + 32'(a));
    endfunction

    // Reference model: reads not yet sampled (with the cycle they were on the
    // bus) and responses not yet consumed, as plain FIFOs.
    int          cyc = 0;
    logic [1:0]  m_req;
    logic [1:0][40:0] m_out;
    int          pend_iss  [2][16];
    logic [7:0]  pend_addr [2][16];
    int          pend_h [2], pend_t [2];
    logic [31:0] rq [2][16];
    int          rq_h [2], rq_t [2];

    function automatic int n_pend(input int k);
        return pend_t[k] - pend_h[k];
    endfunction

    function automatic int n_rsp(input int k);
        return rq_t[k] - rq_h[k];
    endfunction

    function automatic logic exp_ready(input int k);
        return rst_n[k] && (cmd_write[k] || (n_pend(k) + n_rsp(k) < DEPTH));
    endfunction

    task automatic model_step(input int k);
        logic rdy;
        rdy = exp_ready(k);
        if (!rst_n[k]) begin
            pend_h[k] = 0; pend_t[k] = 0; rq_h[k] = 0; rq_t[k] = 0;
            m_req[k] = 1'b0; m_out[k] = '0;
        end else begin
            if (n_rsp(k) > 0 && rsp_ready[k]) rq_h[k]++;
            if (n_pend(k) > 0 && pend_iss[k][pend_h[k] % 16] + lat(k) == cyc) begin
                rq[k][rq_t[k] % 16] = resp_fn(pend_addr[k][pend_h[k] % 16]);
                rq_t[k]++;
                pend_h[k]++;
            end
            m_req[k] = cmd_valid[k] && rdy;
            if (m_req[k]) begin
                m_out[k] = lookup_pack(cmd_write[k], cmd_addr[k], cmd_wdata[k]);
                if (!cmd_write[k]) begin
                    pend_iss[k][pend_t[k] % 16]  = cyc + 1;
                    pend_addr[k][pend_t[k] % 16] = cmd_addr[k];
                    pend_t[k]++;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                string p;
                p = (k == 0) ? "L1" : "L3";
                check({p, " cmd_ready"}, 64'(cmd_ready[k]), 64'(exp_ready(k)));
                check({p, " out_req"},   64'(out_req[k]),   64'(m_req[k]));
                check({p, " out"},       64'(ram_out[k]),   64'(m_out[k]));
                check({p, " rsp_valid"}, 64'(rsp_valid[k]), 64'(n_rsp(k) > 0));
                check({p, " rsp_data"},  64'(rsp_data[k]),
                      64'((n_rsp(k) > 0) ? rq[k][rq_h[k] % 16] : 32'h0));
                check({p, " busy"},      64'(busy[k]),
                      64'(n_pend(k) > 0 || n_rsp(k) > 0 || m_req[k]));
            end
        end
    end

    // Responder: returns resp_fn(addr) exactly LATENCY cycles after a read
    // request, random garbage on every other cycle.
    logic       hist_v [2][8];
    logic [7:0] hist_a [2][8];

    initial begin
        ram_in = '0;
        for (int k = 0; k < 2; k++) for (int j = 0; j < 8; j++) hist_v[k][j] = 1'b0;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                int src;
                hist_v[k][cyc % 8] = out_req[k] && !ram_out[k][40];
                hist_a[k][cyc % 8] = ram_out[k][39:32];
                src = cyc - lat(k);
                if (src >= 0 && hist_v[k][src % 8]) ram_in[k] = resp_fn(hist_a[k][src % 8]);
                else                                ram_in[k] = $urandom;
            end
        end
    end

    // Event log used by the directed checks.
    int          req_cyc [2][64];
    int          req_n   [2];
    logic [31:0] got     [2][64];
    int          got_cyc [2][64];
    int          got_n   [2];
    int          rv_n    [2];

    initial begin
        for (int k = 0; k < 2; k++) begin req_n[k] = 0; got_n[k] = 0; rv_n[k] = 0; end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (out_req[k] && req_n[k] < 64) begin req_cyc[k][req_n[k]] = cyc; req_n[k]++; end
                if (rsp_valid[k]) begin
                    rv_n[k]++;
                    if (rsp_ready[k] && got_n[k] < 64) begin
                        got[k][got_n[k]] = rsp_data[k];
                        got_cyc[k][got_n[k]] = cyc;
                        got_n[k]++;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Holds the command until accepted; returns #1 after the accepting edge.
    task automatic send(input int k, input logic w, input logic [7:0] a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        cmd_valid[k] = 1'b1; cmd_write[k] = w; cmd_addr[k] = a; cmd_wdata[k] = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready[k];
        end
        check("accept within budget", 64'(ok), 64'd1);
        @(posedge clk); #1;
        cmd_valid[k] = 1'b0;
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: run did not finish within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int br, bg, bv;
        rst_n = 2'b00; cmd_valid = 2'b00; cmd_write = 2'b00; rsp_ready = 2'b11;
        cmd_addr = '0; cmd_wdata = '0;

        // Reset state
        step(1);
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("reset out_req", 64'(out_req[k]), 64'd0);
            check("reset out", 64'(ram_out[k]), 64'd0);
            check("reset rsp_valid", 64'(rsp_valid[k]), 64'd0);
            check("reset rsp_data", 64'(rsp_data[k]), 64'd0);
            check("reset busy", 64'(busy[k]), 64'd0);
            check("reset cmd_ready", 64'(cmd_ready[k]), 64'd0);
        end
        step(1);
        rst_n = 2'b11;
        step(1);
        check("post-reset cmd_ready", 64'(cmd_ready[0]), 64'd1);

        // Single read, LATENCY=1; read data field must be zeroed
        send(0, 1'b0, 8'h12, 32'hCAFEF00D);
        check("read out_req", 64'(out_req[0]), 64'd1);
        check("read out", 64'(ram_out[0]), 64'h012_00000000);
        step(1);
        check("read out_req one cycle", 64'(out_req[0]), 64'd0);
        check("read out holds", 64'(ram_out[0]), 64'h012_00000000);
        check("read rsp_valid early", 64'(rsp_valid[0]), 64'd0);
        step(1);
        check("read rsp_valid", 64'(rsp_valid[0]), 64'd1);
        check("read rsp_data", 64'(rsp_data[0]), 64'hDEADBEEF);
        step(1);
        check("read drained", 64'(rsp_valid[0]), 64'd0);
        check("read busy idle", 64'(busy[0]), 64'd0);

        // Write: no response, busy for one cycle
        bv = rv_n[0];
        send(0, 1'b1, 8'h05, 32'hA5A5A5A5);
        check("write out", 64'(ram_out[0]), 64'h1_05_A5A5A5A5);
        check("write busy", 64'(busy[0]), 64'd1);
        step(1);
        check("write busy drop", 64'(busy[0]), 64'd0);
        step(4);
        check("write no rsp", 64'(rv_n[0] - bv), 64'd0);

        // Backpressure: four credits, then stall until the consumer drains
        br = req_n[0]; bg = got_n[0];
        rsp_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 1'b0, 8'(8'h20 + i), 32'hFFFFFFFF);
        cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0; cmd_addr[0] = 8'h24;
        for (int i = 0; i < 3; i++) begin
            check("bp cmd_ready low", 64'(cmd_ready[0]), 64'd0);
            step(1);
        end
        check("bp head data", 64'(rsp_data[0]), 64'h120);
        rsp_ready[0] = 1'b1;
        send(0, 1'b0, 8'h24, 32'hFFFFFFFF);
        send(0, 1'b0, 8'h25, 32'hFFFFFFFF);
        step(10);
        check("bp rsp count", 64'(got_n[0] - bg), 64'd6);
        for (int i = 0; i < 6; i++) check("bp rsp order", 64'(got[0][bg + i]), 64'(32'h120 + 32'(i)));
        check("bp req count", 64'(req_n[0] - br), 64'd6);
        check("bp 5th after drain", 64'(req_cyc[0][br + 4] > got_cyc[0][bg]), 64'd1);

        // Mixed stream R0 W1 R2 W3 R4
        br = req_n[0]; bg = got_n[0];
        for (int i = 0; i < 5; i++) send(0, 1'(i % 2), 8'(i), 32'h11111111 * 32'(i));
        step(8);
        check("mix req count", 64'(req_n[0] - br), 64'd5);
        check("mix back-to-back", 64'(req_cyc[0][br + 4] - req_cyc[0][br]), 64'd4);
        check("mix rsp count", 64'(got_n[0] - bg), 64'd3);
        for (int i = 0; i < 3; i++) check("mix rsp data", 64'(got[0][bg + i]), 64'(32'h100 + 32'(2 * i)));

        // LATENCY=3 instance: four back-to-back reads
        br = req_n[1]; bg = got_n[1];
        for (int i = 0; i < 4; i++) send(1, 1'b0, 8'(8'h30 + i), 32'h0);
        step(12);
        check("lat3 req count", 64'(req_n[1] - br), 64'd4);
        check("lat3 back-to-back", 64'(req_cyc[1][br + 3] - req_cyc[1][br]), 64'd3);
        check("lat3 rsp count", 64'(got_n[1] - bg), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("lat3 rsp data", 64'(got[1][bg + i]), 64'(32'h130 + 32'(i)));
            check("lat3 rsp timing", 64'(got_cyc[1][bg + i] - req_cyc[1][br + i]), 64'd4);
        end

        // Reset while two reads are in flight
        send(0, 1'b0, 8'h40, 32'h0);
        send(0, 1'b0, 8'h41, 32'h0);
        rst_n[0] = 1'b0;
        step(1);
        check("rst out_req", 64'(out_req[0]), 64'd0);
        check("rst busy", 64'(busy[0]), 64'd0);
        rst_n[0] = 1'b1;
        #1;
        check("rst release cmd_ready", 64'(cmd_ready[0]), 64'd1);
        bv = rv_n[0];
        step(1);
        check("rst cmd_ready", 64'(cmd_ready[0]), 64'd1);
        check("rst busy after", 64'(busy[0]), 64'd0);
        step(6);
        check("rst no stale rsp", 64'(rv_n[0] - bv), 64'd0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
